// File: rtl/riscv_mem_responder_pkg.sv
// Shared constants for the RV32I memory responder: data width, MMIO address map,
// CON_STAT bit positions and the NOP returned for fetches outside RAM.
package riscv_mem_responder_pkg;

    localparam int XLEN     = 32;
    localparam int MMIO_BIT = 31;

    typedef enum logic [2:0] {
        OFF_CON_TX      = 3'd0,
        OFF_CON_STAT    = 3'd1,
        OFF_MTIME_LO    = 3'd2,
        OFF_MTIME_HI    = 3'd3,
        OFF_MTIMECMP_LO = 3'd4,
        OFF_MTIMECMP_HI = 3'd5
    } mmio_off_e;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/riscv_mem_con_fifo.sv
// Synchronous FIFO for the console transmit path; head is combinational and
// reads as zero while empty.
module riscv_mem_con_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    // A pop frees the slot the push lands in, so push-while-full is legal then.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = wr_ptr_q + PW'(do_push);
    assign rd_ptr_d = rd_ptr_q + PW'(do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn && do_push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= push_data_i;
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-2:0]];

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder: unified word RAM, console TX FIFO and MMIO decode.
// Optional machine timer with compare interrupt when RISCV_MEM_TIMER_EN is defined.
module riscv_mem_responder
    import riscv_mem_responder_pkg::*;
#(
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = "",
    parameter int    CON_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_mem_pc,
    output logic [XLEN-1:0] o_mem_instr,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic            i_mem_wr_en,
    input  logic [3:0]      i_mem_strb,
    input  logic [XLEN-1:0] i_mem_wr_data,
    output logic [XLEN-1:0] o_mem_rd_data,
    output logic [7:0]      o_con_data,
    output logic            o_con_valid,
    input  logic            i_con_ready,
    output logic            o_timer_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] ram [DEPTH];

    logic [AW-1:0]   d_idx, f_idx;
    logic            d_mmio, mmio_we;
    mmio_off_e       off;
    logic [XLEN-1:0] mmio_rd;

    assign d_idx   = i_mem_addr[AW+1:2];
    assign f_idx   = i_mem_pc[AW+1:2];
    assign d_mmio  = i_mem_addr[MMIO_BIT];
    assign off     = mmio_off_e'(i_mem_addr[4:2]);
    assign mmio_we = i_mem_wr_en & d_mmio;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_mem_addr[XLEN-2:AW+2], i_mem_addr[1:0],
                                i_mem_pc[XLEN-2:AW+2], i_mem_pc[1:0]};

    // RAM ignores reset so a write in the reset cycle still lands.
    always_ff @(posedge i_clk) begin
        if (i_mem_wr_en && !d_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (i_mem_strb[i]) ram[d_idx][8*i +: 8] <= i_mem_wr_data[8*i +: 8];
            end
        end
    end

    assign o_mem_instr   = i_mem_pc[MMIO_BIT] ? NOP_INSTR : ram[f_idx];
    assign o_mem_rd_data = d_mmio ? mmio_rd : ram[d_idx];

    logic con_push, con_pop, con_full, con_empty, stat_clr;
    logic ovf_q, ovf_d;

    assign con_push    = mmio_we & (off == OFF_CON_TX) & i_mem_strb[0];
    assign stat_clr    = mmio_we & (off == OFF_CON_STAT) & i_mem_wr_data[STAT_OVF];
    assign o_con_valid = ~con_empty;
    assign con_pop     = o_con_valid & i_con_ready;

    riscv_mem_con_fifo #(
        .DEPTH (CON_DEPTH),
        .WIDTH (8)
    ) u_con_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .push_i      (con_push),
        .push_data_i (i_mem_wr_data[7:0]),
        .pop_i       (i_con_ready),
        .head_o      (o_con_data),
        .full_o      (con_full),
        .empty_o     (con_empty)
    );

    // A new drop outranks a same-cycle clear so the event is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_clr) ovf_d = 1'b0;
        if (con_push && con_full && !con_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

`ifdef RISCV_MEM_TIMER_EN
    logic [63:0] mtime_q, mtime_d, mtcmp_q, mtcmp_d;
    logic        irq_q;

    always_comb begin
        mtime_d = mtime_q + 64'd1;
        mtcmp_d = mtcmp_q;
        if (mmio_we) begin
            case (off)
                OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], i_mem_wr_data};
                OFF_MTIME_HI:    mtime_d = {i_mem_wr_data, mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtcmp_d = {mtcmp_q[63:32], i_mem_wr_data};
                OFF_MTIMECMP_HI: mtcmp_d = {i_mem_wr_data, mtcmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mtime_q <= '0;
            mtcmp_q <= MTIMECMP_RST;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            mtcmp_q <= mtcmp_d;
            irq_q   <= (mtime_q >= mtcmp_q);
        end
    end

    assign o_timer_irq = irq_q;
`else
    assign o_timer_irq = 1'b0;
`endif

    always_comb begin
        mmio_rd = '0;
        case (off)
            OFF_CON_STAT:    mmio_rd = {29'b0, ovf_q, con_full, con_empty};
`ifdef RISCV_MEM_TIMER_EN
            OFF_MTIME_LO:    mmio_rd = mtime_q[31:0];
            OFF_MTIME_HI:    mmio_rd = mtime_q[63:32];
            OFF_MTIMECMP_LO: mmio_rd = mtcmp_q[31:0];
            OFF_MTIMECMP_HI: mmio_rd = mtcmp_q[63:32];
`endif
            default:         mmio_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed vector table, FIFO/timer/reset
// sequences, then randomized traffic against a queue/array reference model.
module tb_riscv_mem_responder;

    localparam int DEPTH = 4096;
    localparam int CD    = 8;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_mem_pc, i_mem_addr, i_mem_wr_data;
    logic        i_mem_wr_en;
    logic [3:0]  i_mem_strb;
    logic        i_con_ready;
    logic [31:0] o_mem_instr, o_mem_rd_data;
    logic [7:0]  o_con_data;
    logic        o_con_valid, o_timer_irq;

    always #5 i_clk = ~i_clk;

    riscv_mem_responder #(
        .DEPTH     (DEPTH),
        .INIT_FILE (""),
        .CON_DEPTH (CD)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_mem_pc      (i_mem_pc),
        .o_mem_instr   (o_mem_instr),
        .i_mem_addr    (i_mem_addr),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_strb    (i_mem_strb),
        .i_mem_wr_data (i_mem_wr_data),
        .o_mem_rd_data (o_mem_rd_data),
        .o_con_data    (o_con_data),
        .o_con_valid   (o_con_valid),
        .i_con_ready   (i_con_ready),
        .o_timer_irq   (o_timer_irq)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mram [int];
    logic [7:0]  mq [$];
    logic        movf;
    logic [63:0] mtime, mcmp;
    logic        mirq;

    logic [31:0] act_rd, act_in, exp_rd, exp_in;
    logic [7:0]  act_data, exp_data;
    logic        act_valid, act_irq, exp_valid, exp_irq;
    bit          exp_rd_known, exp_in_known;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    task automatic drive(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        i_mem_wr_en   = we;
        i_mem_addr    = a;
        i_mem_strb    = s;
        i_mem_wr_data = d;
    endtask

    task automatic model_expect();
        int k;
        exp_rd_known = 1'b1;
        exp_rd       = 32'h0;
        if (i_mem_addr[31]) begin
            case (int'(i_mem_addr[4:2]))
                1: exp_rd = {29'b0, movf, mq.size() == CD, mq.size() == 0};
`ifdef RISCV_MEM_TIMER_EN
                2: exp_rd = mtime[31:0];
                3: exp_rd = mtime[63:32];
                4: exp_rd = mcmp[31:0];
                5: exp_rd = mcmp[63:32];
`endif
                default: exp_rd = 32'h0;
            endcase
        end else begin
            k = widx(i_mem_addr);
            exp_rd_known = mram.exists(k);
            if (exp_rd_known) exp_rd = mram[k];
        end
        exp_in_known = 1'b1;
        if (i_mem_pc[31]) exp_in = 32'h0000_0013;
        else begin
            k = widx(i_mem_pc);
            exp_in_known = mram.exists(k);
            exp_in = exp_in_known ? mram[k] : 32'h0;
        end
        exp_valid = (mq.size() != 0);
        exp_data  = exp_valid ? mq[0] : 8'h00;
        exp_irq   = mirq;
    endtask

    task automatic model_update();
        int          k;
        logic [31:0] w;
        logic [63:0] nt;
        bit          full_b, pop, push;
        if (i_mem_wr_en && !i_mem_addr[31]) begin
            k = widx(i_mem_addr);
            if (i_mem_strb == 4'hF) mram[k] = i_mem_wr_data;
            else if (mram.exists(k)) begin
                w = mram[k];
                for (int b = 0; b < 4; b++)
                    if (i_mem_strb[b]) w[8*b +: 8] = i_mem_wr_data[8*b +: 8];
                mram[k] = w;
            end
        end
        if (!i_rstn) begin
            mq.delete();
            movf  = 1'b0;
            mtime = 64'h0;
            mcmp  = '1;
            mirq  = 1'b0;
        end else begin
            full_b = (mq.size() == CD);
            pop    = (mq.size() != 0) && i_con_ready;
            push   = i_mem_wr_en && i_mem_addr[31] && i_mem_addr[4:2] == 3'd0 && i_mem_strb[0];
            if (i_mem_wr_en && i_mem_addr[31] && i_mem_addr[4:2] == 3'd1 && i_mem_wr_data[2])
                movf = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (full_b && !pop) movf = 1'b1;
                else mq.push_back(i_mem_wr_data[7:0]);
            end
`ifdef RISCV_MEM_TIMER_EN
            mirq = (mtime >= mcmp);
            nt   = mtime + 64'd1;
            if (i_mem_wr_en && i_mem_addr[31]) begin
                case (int'(i_mem_addr[4:2]))
                    2: nt = {mtime[63:32], i_mem_wr_data};
                    3: nt = {i_mem_wr_data, mtime[31:0]};
                    4: mcmp[31:0]  = i_mem_wr_data;
                    5: mcmp[63:32] = i_mem_wr_data;
                    default: ;
                endcase
            end
            mtime = nt;
`endif
        end
    endtask

    // Inputs are set after a negedge; outputs are sampled 2 time units later,
    // then the model advances on the rising edge.
    task automatic tick();
        #2;
        act_rd    = o_mem_rd_data;
        act_in    = o_mem_instr;
        act_valid = o_con_valid;
        act_data  = o_con_data;
        act_irq   = o_timer_irq;
        model_expect();
        @(posedge i_clk);
        model_update();
        @(negedge i_clk);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] pc;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_in;
        logic [31:0] exp_in;
    } vec_t;

    function automatic vec_t mkv(input string n, input logic we, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d, input logic [31:0] pc,
                                 input bit cr, input logic [31:0] er, input bit ci,
                                 input logic [31:0] ei);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.strb = s; v.wdata = d; v.pc = pc;
        v.chk_rd = cr; v.exp_rd = er; v.chk_in = ci; v.exp_in = ei;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        logic [7:0]  exp_bytes [$];
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        we;
        int          kind, bias;
        bit          reached;

        movf = 1'b0; mtime = '0; mcmp = '1; mirq = 1'b0;
        i_rstn = 1'b0; i_con_ready = 1'b0; i_mem_pc = 32'h8000_0000;
        drive(1'b0, 32'h8000_0004, 4'h0, 32'h0);
        @(negedge i_clk);
        tick(); tick();
        i_rstn = 1'b1;

        // reset state
        tick();
        check("rst_valid", act_valid, 1'b0);
        check("rst_data", act_data, 8'h00);
        check("rst_irq", act_irq, 1'b0);
        check("rst_stat", act_rd, 32'h1);
`ifdef RISCV_MEM_TIMER_EN
        drive(1'b0, 32'h8000_0014, 4'h0, 32'h0);
        tick();
        check("rst_mtimecmp_hi", act_rd, 32'hFFFF_FFFF);
`endif

        tbl.push_back(mkv("w40", 1, 32'h40, 4'hF, 32'hAABBCCDD, 32'h8000_0000, 0, 0, 1, 32'h13));
        tbl.push_back(mkv("strb_old", 1, 32'h40, 4'b0010, 32'h0000_1100, 32'h8000_0000, 1, 32'hAABBCCDD, 0, 0));
        tbl.push_back(mkv("strb_merge", 0, 32'h40, 4'h0, 0, 32'h8000_0000, 1, 32'hAABB11DD, 0, 0));
        tbl.push_back(mkv("low_bits", 0, 32'h43, 4'h0, 0, 32'h8000_0000, 1, 32'hAABB11DD, 0, 0));
        tbl.push_back(mkv("alias_a", 0, 32'h4040, 4'h0, 0, 32'h8000_0000, 1, 32'hAABB11DD, 0, 0));
        tbl.push_back(mkv("alias_b", 0, 32'h7FFF_0041, 4'h0, 0, 32'h8000_0000, 1, 32'hAABB11DD, 0, 0));
        tbl.push_back(mkv("w44", 1, 32'h44, 4'hF, 32'h12345678, 32'h8000_0000, 0, 0, 0, 0));
        tbl.push_back(mkv("zero_strb", 1, 32'h44, 4'h0, 32'hFFFFFFFF, 32'h8000_0000, 1, 32'h12345678, 0, 0));
        tbl.push_back(mkv("zero_strb_keep", 0, 32'h44, 4'h0, 0, 32'h8000_0000, 1, 32'h12345678, 0, 0));
        tbl.push_back(mkv("strb_1001", 1, 32'h44, 4'b1001, 32'hA5FFFFC3, 32'h8000_0000, 1, 32'h12345678, 0, 0));
        tbl.push_back(mkv("strb_1001_rd", 0, 32'h44, 4'h0, 0, 32'h8000_0000, 1, 32'hA53456C3, 0, 0));
        tbl.push_back(mkv("fetch_wr", 1, 32'h0, 4'hF, 32'h00500093, 32'h8000_0000, 0, 0, 0, 0));
        tbl.push_back(mkv("fetch_pc0", 0, 32'h40, 4'h0, 0, 32'h0, 1, 32'hAABB11DD, 1, 32'h00500093));
        tbl.push_back(mkv("fetch_pc_lowbits", 0, 32'h0, 4'h0, 0, 32'h2, 1, 32'h00500093, 1, 32'h00500093));
        tbl.push_back(mkv("fetch_mmio", 0, 32'h0, 4'h0, 0, 32'h8000_0000, 0, 0, 1, 32'h13));
        tbl.push_back(mkv("fetch_mmio_top", 0, 32'h0, 4'h0, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'h13));
        tbl.push_back(mkv("unmapped_wr", 1, 32'h8000_0018, 4'hF, 32'hFFFFFFFF, 32'h8000_0000, 1, 32'h0, 0, 0));
        tbl.push_back(mkv("unmapped_rd6", 0, 32'h8000_0018, 4'h0, 0, 32'h8000_0000, 1, 32'h0, 0, 0));
        tbl.push_back(mkv("unmapped_rd7", 0, 32'h8000_001C, 4'h0, 0, 32'h8000_0000, 1, 32'h0, 0, 0));
        tbl.push_back(mkv("con_tx_rd", 0, 32'h8000_0000, 4'h0, 0, 32'h8000_0000, 1, 32'h0, 0, 0));
        tbl.push_back(mkv("stat_idle", 0, 32'h8000_0004, 4'h0, 0, 32'h8000_0000, 1, 32'h1, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].strb, tbl[i].wdata);
            i_mem_pc = tbl[i].pc;
            tick();
            if (tbl[i].chk_rd) check({tbl[i].name, "_rd"}, act_rd, tbl[i].exp_rd);
            if (tbl[i].chk_in) check({tbl[i].name, "_instr"}, act_in, tbl[i].exp_in);
        end
        i_mem_pc = 32'h8000_0000;

        // FIFO overflow and drain
        i_con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h8000_0000, 4'b0001, 32'h41 + i);
            tick();
        end
        drive(1'b0, 32'h8000_0004, 4'h0, 32'h0);
        tick();
        check("ovf_stat", act_rd, 32'h6);
        check("ovf_head", act_data, 8'h41);
        check("ovf_valid", act_valid, 1'b1);
        i_con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drain_valid", act_valid, 1'b1);
            check("drain_data", act_data, 8'h41 + i);
        end
        tick();
        check("drained_valid", act_valid, 1'b0);
        check("drained_stat", act_rd, 32'h5);
        i_con_ready = 1'b0;
        drive(1'b1, 32'h8000_0004, 4'hF, 32'h4);
        tick();
        drive(1'b0, 32'h8000_0004, 4'h0, 32'h0);
        tick();
        check("ovf_clear", act_rd, 32'h1);

        // push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h8000_0000, 4'b0001, 32'h61 + i);
            tick();
        end
        i_con_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 4'b0001, 32'h5A);
        tick();
        check("fullpp_head", act_data, 8'h61);
        i_con_ready = 1'b0;
        drive(1'b0, 32'h8000_0004, 4'h0, 32'h0);
        tick();
        check("fullpp_stat", act_rd, 32'h2);
        check("fullpp_stable_head", act_data, 8'h62);
        tick();
        check("stall_stable_head", act_data, 8'h62);
        exp_bytes = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
        i_con_ready = 1'b1;
        foreach (exp_bytes[i]) begin
            tick();
            check("fullpp_drain", act_data, exp_bytes[i]);
        end
        tick();
        check("fullpp_empty", act_valid, 1'b0);
        i_con_ready = 1'b0;

`ifdef RISCV_MEM_TIMER_EN
        i_rstn = 1'b0;
        drive(1'b0, 32'h8000_0008, 4'h0, 32'h0);
        tick();
        i_rstn = 1'b1;
        drive(1'b1, 32'h8000_0014, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h8000_0010, 4'h0, 32'd20);
        tick();
        drive(1'b0, 32'h8000_0008, 4'h0, 32'h0);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            if (act_rd <= 32'd20) check("irq_low", act_irq, 1'b0);
            else check("irq_high", act_irq, 1'b1);
            if (act_rd >= 32'd24) reached = 1'b1;
        end
        check("mtime_reached", reached, 1'b1);
        drive(1'b1, 32'h8000_0008, 4'hF, 32'h0);
        tick();
        check("irq_before_wr", act_irq, 1'b1);
        drive(1'b0, 32'h8000_0008, 4'h0, 32'h0);
        tick();
        check("mtime_written", act_rd, 32'h0);
        check("irq_lag", act_irq, 1'b1);
        tick();
        check("mtime_inc", act_rd, 32'h1);
        check("irq_drop", act_irq, 1'b0);
`else
        drive(1'b1, 32'h8000_0010, 4'hF, 32'h0);
        tick();
        for (int o = 2; o < 6; o++) begin
            drive(1'b0, 32'h8000_0000 | (o << 2), 4'h0, 32'h0);
            tick();
            check("timer_off_rd", act_rd, 32'h0);
            check("timer_off_irq", act_irq, 1'b0);
        end
`endif

        // reset with bytes queued; RAM write in the reset cycle still lands
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0000, 4'b0001, 32'h31 + i);
            tick();
        end
        i_rstn = 1'b0;
        drive(1'b1, 32'h14, 4'hF, 32'hDEADBEEF);
        tick();
        i_rstn = 1'b1;
        drive(1'b0, 32'h8000_0008, 4'h0, 32'h0);
        tick();
        check("midrst_valid", act_valid, 1'b0);
        check("midrst_data", act_data, 8'h00);
        check("midrst_mtime", act_rd, 32'h0);
        drive(1'b0, 32'h8000_0004, 4'h0, 32'h0);
        tick();
        check("midrst_stat", act_rd, 32'h1);
        drive(1'b0, 32'h14, 4'h0, 32'h0);
        tick();
        check("midrst_ram", act_rd, 32'hDEADBEEF);

        // randomized traffic against the reference model
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i * 4, 4'hF, $urandom);
            tick();
        end
        bias = 2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) bias = $urandom_range(0, 4);
            i_con_ready = ($urandom_range(0, 3) < bias);
            i_rstn      = ($urandom_range(0, 299) != 0);
            kind = $urandom_range(0, 9);
            we   = $urandom_range(0, 1);
            s    = 4'($urandom);
            d    = $urandom;
            case (kind)
                0, 1, 2, 3: a = {1'b0, 17'($urandom), 8'h0, 4'($urandom), 2'($urandom)};
                4, 5: begin a = 32'h8000_0000; we = ($urandom_range(0, 3) != 0); end
                6: begin a = 32'h8000_0004; d = {29'($urandom), 3'($urandom)}; end
                7: begin
                    a = 32'h8000_0000 | (32'($urandom_range(2, 5)) << 2);
                    d = a[2] ? 32'h0 : $urandom_range(0, 400);
                end
                8: a = 32'h8000_0018 | (32'($urandom_range(0, 1)) << 2);
                default: begin a = {1'b1, 31'($urandom)}; we = 1'b0; end
            endcase
            drive(we, a, s, d);
            i_mem_pc = $urandom_range(0, 1) ? {1'b1, 31'($urandom)}
                                            : {1'b0, 17'($urandom), 8'h0, 4'($urandom), 2'($urandom)};
            tick();
            if (exp_rd_known) check("rnd_rd", act_rd, exp_rd);
            if (exp_in_known) check("rnd_instr", act_in, exp_in);
            check("rnd_valid", act_valid, exp_valid);
            check("rnd_data", act_data, exp_data);
            check("rnd_irq", act_irq, exp_irq);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
